// File: rtl/rx_pkt_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_pkt_gen_pkg : shared header field offsets, FSM encoding and length limit
// Revision: 1.0
// ---------------------------------------------------------------------------
package rx_pkt_gen_pkg;

    localparam int LEN_LSB     = 0;
    localparam int LEN_MSB     = 15;
    localparam int GAP_LSB     = 16;
    localparam int GAP_MSB     = 31;
    localparam int MAX_LEN_DEF = 2044;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_RD   = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_DATA     = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_pkt_gen_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_pkt_gen_skid_fifo : small synchronous FIFO with occupancy count
// Revision: 1.0
// ---------------------------------------------------------------------------
module rx_pkt_gen_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/rx_pkt_gen_rdr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_pkt_gen_rdr : plays packet records from RAM port B out as an RX stream
// Revision: 1.0
// ---------------------------------------------------------------------------
module rx_pkt_gen_rdr
    import rx_pkt_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_sop,
    output logic                  rx_eop,
    output logic [1:0]            rx_mod,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic                  err
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int USED_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam int FW     = DATA_WIDTH + 4;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, base_q, base_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [15:0]           gap_q, gap_d, gap_cnt_q, gap_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [14:0]           words_q, words_d;
    logic [1:0]            mod_q, mod_d;
    logic                  first_q, first_d, stop_pend_q, stop_pend_d, err_q, err_d;
    logic [RD_LAT-1:0]     pv_q, ps_q, pe_q;

    logic                  w_issue, w_hdr_rd, w_pop, w_eop_acc, w_credit;
    logic                  w_empty, w_full;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [USED_W-1:0]     w_used;
    logic [15:0]           w_len, w_hdr_gap;
    logic [16:0]           w_len_p3;
    logic [FW-1:0]         w_fifo_din, w_fifo_dout;

    assign w_len     = ram_dout[LEN_MSB:LEN_LSB];
    assign w_hdr_gap = ram_dout[GAP_MSB:GAP_LSB];
    assign w_len_p3  = {1'b0, w_len} + 17'd3;

    // Occupancy plus reads still in the RAM pipeline bounds what can land in the FIFO.
    always_comb begin
        w_used = USED_W'(w_fifo_cnt);
        for (int i = 0; i < RD_LAT; i++) begin
            w_used = w_used + USED_W'(pv_q[i]);
        end
    end
    assign w_credit = (w_used < USED_W'(FIFO_DEPTH));

    assign w_pop     = rx_valid & rx_ready;
    assign w_eop_acc = w_pop & rx_eop;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        base_d      = base_q;
        wait_d      = wait_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        words_d     = words_q;
        mod_d       = mod_q;
        first_d     = first_q;
        err_d       = err_q;
        pkt_cnt_d   = pkt_cnt_q;
        stop_pend_d = stop_pend_q | stop;
        w_issue     = 1'b0;
        w_hdr_rd    = 1'b0;
        if (w_eop_acc) pkt_cnt_d = pkt_cnt_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    rd_ptr_d  = base_addr;
                    base_d    = base_addr;
                    err_d     = 1'b0;
                    pkt_cnt_d = 16'd0;
                    state_d   = ST_HDR_RD;
                end
            end
            ST_HDR_RD: begin
                w_hdr_rd = 1'b1;
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                wait_d   = '0;
                state_d  = ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                if (stop_pend_d) begin
                    stop_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    if (w_len == 16'd0) begin
                        if (loop_en) begin
                            rd_ptr_d = base_q;
                            state_d  = ST_HDR_RD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (w_len > 16'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        words_d = w_len_p3[16:2];
                        mod_d   = w_len[1:0] - 2'd1;
                        gap_d   = w_hdr_gap;
                        first_d = 1'b1;
                        state_d = ST_DATA;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DATA: begin
                if ((words_q != 15'd0) && w_credit) begin
                    w_issue  = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    words_d  = words_q - 15'd1;
                    first_d  = 1'b0;
                end
                if (w_eop_acc) begin
                    if (gap_q != 16'd0) begin
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end else if (stop_pend_d) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_HDR_RD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 16'd1) begin
                    if (stop_pend_d) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_HDR_RD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            base_q      <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            words_q     <= '0;
            mod_q       <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            pv_q        <= '0;
            ps_q        <= '0;
            pe_q        <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            base_q      <= base_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            words_q     <= words_d;
            mod_q       <= mod_d;
            first_q     <= first_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stop_pend_q <= stop_pend_d;
            // Tags travel alongside each data read so they meet the word on ram_dout.
            pv_q[0]     <= w_issue;
            ps_q[0]     <= w_issue & first_q;
            pe_q[0]     <= w_issue & (words_q == 15'd1);
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign w_fifo_din = {ps_q[RD_LAT-1], pe_q[RD_LAT-1],
                         (pe_q[RD_LAT-1] ? mod_q : 2'b00), ram_dout};

    rx_pkt_gen_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .push_i  (pv_q[RD_LAT-1]),
        .din_i   (w_fifo_din),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_dout),
        .empty_o (w_empty),
        .full_o  (w_full),
        .count_o (w_fifo_cnt)
    );

    assign rx_valid = ~w_empty;
    assign rx_data  = rx_valid ? w_fifo_dout[DATA_WIDTH-1:0] : '0;
    assign rx_mod   = rx_valid ? w_fifo_dout[DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
    assign rx_eop   = rx_valid & w_fifo_dout[DATA_WIDTH+2];
    assign rx_sop   = rx_valid & w_fifo_dout[DATA_WIDTH+3];

    assign ram_addr = rd_ptr_q;
    assign ram_en   = w_hdr_rd | w_issue;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt  = pkt_cnt_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_gen_rdr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rx_pkt_gen_rdr : scoreboard bench with a record-walking reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_pkt_gen_rdr;
    localparam int AW     = 11;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int MAXL   = 2044;

    logic          clk = 1'b0, reset_ = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_en, ram_we;
    logic [DW-1:0] ram_din, ram_dout, rx_data;
    logic          rx_valid, rx_sop, rx_eop, rx_ready, busy, err;
    logic [1:0]    rx_mod;
    logic [15:0]   pkt_cnt;

    logic [31:0] mem [2048];
    logic [31:0] rd_s1 = '0, rd_s2 = '0;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0, n_total = 0, n_acc = 0, cyc = 0;
    int last_eop_cyc = 0, sop_cyc = 0, idle_cyc = 0;
    bit rand_rdy = 1'b0;

    rx_pkt_gen_rdr #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LAT (RD_LAT),
        .FIFO_DEPTH (4), .MAX_LEN (MAXL)
    ) dut (
        .clk (clk), .reset_ (reset_), .start (start), .stop (stop),
        .loop_en (loop_en), .base_addr (base_addr),
        .ram_addr (ram_addr), .ram_en (ram_en), .ram_we (ram_we),
        .ram_din (ram_din), .ram_dout (ram_dout),
        .rx_data (rx_data), .rx_valid (rx_valid), .rx_sop (rx_sop),
        .rx_eop (rx_eop), .rx_mod (rx_mod), .rx_ready (rx_ready),
        .busy (busy), .pkt_cnt (pkt_cnt), .err (err)
    );

    always #5 clk = ~clk;

    // Port B of the packet RAM: two-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) rd_s1 <= mem[ram_addr];
        rd_s2 <= rd_s1;
    end
    assign ram_dout = rd_s2;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_total++;
        if (got >= lo && got <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    endtask

    task automatic put_hdr(input int a, input int len, input int gap);
        mem[a & 2047] = {gap[15:0], len[15:0]};
    endtask

    task automatic put_pkt(input int a_in, input int len, input int gap, output int a_out);
        int a;
        a = a_in & 2047;
        put_hdr(a, len, gap);
        a = (a + 1) & 2047;
        for (int k = 0; k < (len + 3) / 4; k++) begin
            mem[a] = $urandom;
            a = (a + 1) & 2047;
        end
        a_out = a;
    endtask

    // Walks the record table as the host wrote it and queues the words expected on the stream.
    task automatic model(input int base, input int max_pkts, input bit lp);
        int a, n, len, nw, guard;
        logic [31:0] h;
        exp_t e;
        a = base; n = 0; guard = 0;
        while (n < max_pkts && guard < 64) begin
            guard++;
            h   = mem[a];
            len = int'(h[15:0]);
            a   = (a + 1) & 2047;
            if (len == 0) begin
                if (!lp) break;
                a = base;
                continue;
            end
            if (len > MAXL) break;
            nw = (len + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                e.d   = mem[a];
                e.sop = (k == 0);
                e.eop = (k == nw - 1);
                e.mod = (k == nw - 1) ? 2'((len - 1) % 4) : 2'd0;
                exp_q.push_back(e);
                a = (a + 1) & 2047;
            end
            n++;
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stall stability.
    initial begin
        exp_t e, got, stall_w;
        bit   stall_v;
        stall_v = 1'b0;
        stall_w = '0;
        forever begin
            @(negedge clk);
            if (!reset_) begin
                stall_v = 1'b0;
            end else begin
                got = {rx_sop, rx_eop, rx_mod, rx_data};
                if (stall_v) check("hold_stable", 64'({rx_valid, got}), 64'({1'b1, stall_w}));
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_word: got %0h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_word", 64'(got), 64'(e));
                    end
                    n_acc++;
                    if (rx_sop) sop_cyc = cyc;
                    if (rx_eop) last_eop_cyc = cyc;
                end
                stall_v = rx_valid && !rx_ready;
                stall_w = got;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        base_addr = AW'(b);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        if (busy) begin
            n_total++;
            $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", tag, n);
        end
        idle_cyc = cyc;
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n;
        n = 0;
        while (n_acc < target && n < 3000) begin
            tick(1);
            n++;
        end
        if (n_acc < target) begin
            n_total++;
            $display("FAIL %s_timeout: accepted %0d words, required %0d", tag, n_acc, target);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_data"}, 64'(rx_data), 64'd0);
        check({tag, "_ram_din"}, 64'(ram_din), 64'd0);
        check({tag, "_ctrl"}, 64'({ram_addr, ram_en, ram_we, rx_valid, rx_sop, rx_eop,
                                  rx_mod, busy, err, pkt_cnt}), 64'd0);
    endtask

    initial begin
        int a, acc0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        tick(3);
        check_zero("reset");
        reset_ = 1'b1;
        tick(2);

        // Single 64-byte packet, gap 12, full-rate sink.
        put_pkt(0, 64, 12, a);
        put_hdr(a, 0, 0);
        model(0, 100, 1'b0);
        do_start(0);
        wait_idle("A");
        check("A_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("A_drained", 64'(exp_q.size()), 64'd0);
        check("A_contiguous", 64'(last_eop_cyc - sop_cyc), 64'd15);
        check_range("A_gap_to_idle", idle_cyc - last_eop_cyc, 13, 12 + RD_LAT + 4);

        // Odd lengths exercise every rx_mod value; random backpressure.
        rand_rdy = 1'b1;
        a = 12'h400;
        put_pkt(a, 61, $urandom_range(0, 4), a);
        put_pkt(a, 62, $urandom_range(0, 4), a);
        put_pkt(a, 63, $urandom_range(0, 4), a);
        put_hdr(a, 0, 0);
        model(12'h400, 100, 1'b0);
        do_start(12'h400);
        wait_idle("B");
        check("B_pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("B_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back packets with zero gap under random stalls.
        a = 12'h500;
        put_pkt(a, 64, 0, a);
        put_pkt(a, 64, 0, a);
        put_hdr(a, 0, 0);
        model(12'h500, 100, 1'b0);
        do_start(12'h500);
        wait_idle("C");
        check("C_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check("C_drained", 64'(exp_q.size()), 64'd0);

        // Record straddling the top of the address space.
        rand_rdy = 1'b0;
        put_pkt(12'h7FE, 20, 1, a);
        put_hdr(a, 0, 0);
        model(12'h7FE, 100, 1'b0);
        do_start(12'h7FE);
        wait_idle("D");
        check("D_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("D_drained", 64'(exp_q.size()), 64'd0);

        // Looping table, stop in the middle of the fifth packet.
        rand_rdy = 1'b1;
        a = 12'h300;
        put_pkt(a, 16, 3, a);
        put_pkt(a, 40, 0, a);
        put_pkt(a, 23, 5, a);
        put_hdr(a, 0, 0);
        model(12'h300, 5, 1'b1);
        loop_en = 1'b1;
        acc0 = n_acc;
        do_start(12'h300);
        wait_acc(acc0 + 4 + 10 + 6 + 4 + 3, "E_mid");
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("E");
        loop_en = 1'b0;
        check("E_pkt_cnt", 64'(pkt_cnt), 64'd5);
        check("E_drained", 64'(exp_q.size()), 64'd0);

        // Oversized length flags err without emitting data; next start clears it.
        put_hdr(12'h100, 2100, 0);
        do_start(12'h100);
        wait_idle("F");
        check("F_err_set", 64'(err), 64'd1);
        check("F_pkt_cnt", 64'(pkt_cnt), 64'd0);
        put_pkt(12'h120, 8, 0, a);
        put_hdr(a, 0, 0);
        model(12'h120, 100, 1'b0);
        do_start(12'h120);
        check("F_err_clear", 64'(err), 64'd0);
        wait_idle("F2");
        check("F2_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Reset in the middle of a packet discards it at once.
        rand_rdy = 1'b0;
        put_pkt(12'h200, 64, 0, a);
        put_hdr(a, 0, 0);
        model(12'h200, 100, 1'b0);
        acc0 = n_acc;
        do_start(12'h200);
        wait_acc(acc0 + 4, "G_mid");
        reset_ = 1'b0;
        #1;
        check_zero("G_async");
        exp_q.delete();
        tick(3);
        reset_ = 1'b1;
        tick(3);
        check_zero("G_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_pkt_gen_rdr.md
Name: rx_pkt_gen_rdr

Overview:
- Reads pre-loaded packet records from port B of the PHY emulator's 2Kx32 dual-port packet RAM and plays them out as a 32-bit SOP/EOP/valid/ready stream into the MAC RX path.
- Port A of the RAM stays with the host loader.
- Provides start/stop/loop control, per-record inter-packet gap, backpressure handling across the RAM's 2-cycle read latency, and packet/error status.

Parameters:
ADDR_WIDTH, 11, RAM address width (2048 words)
DATA_WIDTH, 32, RAM and stream word width
RD_LAT, 2, RAM port B read latency in cycles (address to dout_b)
FIFO_DEPTH, 4, output skid FIFO depth in words; must be at least RD_LAT+2
MAX_LEN, 2044, largest legal packet length in bytes

Ports:
clk  in  1  single clock for block and RAM port B
reset_  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin playback at base_addr
stop  in  1  one-cycle pulse; finish current packet, then go idle
loop_en  in  1  on end-of-table, restart at base_addr instead of idling
base_addr  in  ADDR_WIDTH  first record address, sampled on start
ram_addr  out  ADDR_WIDTH  RAM port B address
ram_en  out  1  RAM port B enable (read strobe)
ram_we  out  1  tied 0
ram_din  out  DATA_WIDTH  tied 0
ram_dout  in  DATA_WIDTH  RAM port B read data, valid RD_LAT cycles after ram_en
rx_data  out  DATA_WIDTH  stream data, byte 0 in [31:24]
rx_valid  out  1  stream word valid
rx_sop  out  1  first word of packet
rx_eop  out  1  last word of packet
rx_mod  out  2  valid bytes on EOP word minus 1; 0 when not EOP
rx_ready  in  1  downstream accepts word when rx_valid&rx_ready
busy  out  1  state is not IDLE
pkt_cnt  out  16  packets fully emitted since start, wraps at 16'hFFFF
err  out  1  sticky bad-length flag; cleared by start

Behaviour:
- Record format:
  - Header word: [31:16] gap in idle cycles after EOP; [15:0] byte length.
  - Followed by ceil(len/4) data words.
  - Next header immediately follows the last data word.
  - Addresses wrap 2047 -> 0.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; credit counter 0.
- FSM states: IDLE, HDR_RD, HDR_WAIT, DATA, GAP.
  - IDLE: on start, load rd_ptr=base_addr, clear err and pkt_cnt, go to HDR_RD. start is ignored while busy.
  - HDR_RD: assert ram_en at rd_ptr for 1 cycle, increment rd_ptr, go to HDR_WAIT.
  - HDR_WAIT: wait RD_LAT cycles, then latch len and gap.
    - len==0 (end of table): go to HDR_RD with rd_ptr=base_addr if loop_en, else IDLE.
    - len>MAX_LEN: set err, go to IDLE.
    - Otherwise: words_left=ceil(len/4), go to DATA.
  - DATA: issue one read per cycle while words_left>0 and credits allow. Each returned word is pushed to the FIFO, tagged with sop (first word), eop (last word) and mod=(len-1)%4. Leave DATA when the EOP word has been popped to the stream.
  - GAP: count gap cycles with rx_valid=0. gap==0 means the next header read may start the cycle after EOP is accepted. At the end of the gap: if a stop is pending, go to IDLE; else go to HDR_RD.
- Credit rule: issue a read only if (FIFO occupancy + reads in flight) < FIFO_DEPTH. This makes FIFO overflow impossible under any rx_ready pattern.
- Output: rx_valid/rx_data/flags are FIFO head, registered. Word held stable while rx_valid & !rx_ready.
- Throughput: with rx_ready held high and gap 0, back-to-back data words with no bubbles inside a packet. Latency from start pulse to first rx_valid is 2+RD_LAT+1 cycles.
- pkt_cnt increments on the cycle an EOP word is accepted.
- stop: stored as a pending flag; honoured only at packet boundaries, and in IDLE/HDR_WAIT it takes effect immediately. A packet is never truncated.
- start and stop in the same cycle while IDLE: start wins; stop is dropped.
- reset_ asserted mid-packet: immediate return to reset values; the partial packet is discarded with no EOP.

Decomposition:
- Shared package rx_pkt_gen_pkg: header field offsets (LEN_LSB=0, LEN_MSB=15, GAP_LSB=16, GAP_MSB=31), FSM state encoding, MAX_LEN default.
- One sub-module: rx_pkt_gen_skid_fifo (synchronous FIFO, FIFO_DEPTH x (DATA_WIDTH+4) bits, exposes occupancy count).

Test Plan:
- Single 64-byte packet at base 0x000, gap 12, then len 0; rx_ready=1 -> 16 contiguous words, sop on word 0, eop on word 15, rx_mod=3, pkt_cnt=1, busy drops after gap.
- 61-byte packet -> 16 words, rx_mod=0 on EOP; 62/63 bytes -> rx_mod=1/2.
- Two 64-byte packets with gap 0, rx_ready toggling at random 50% -> data order exact, no drop or duplicate, FIFO never overflows, every rx_data held stable while stalled.
- Record starting at 0x7FE spanning the wrap to 0x000 -> data read in order 0x7FF, 0x000, ...; packet correct.
- loop_en=1 with 3 records -> sequence repeats; stop pulsed mid-packet 2 -> packet 2 completes with EOP, then IDLE, pkt_cnt=5 (loop 1 plus two).
- Header len=2100 -> err=1, no rx_valid, IDLE; then start -> err clears. reset_ low mid-packet -> all outputs 0 next edge.
